// File: rtl/shared_reg_arbiter.sv
// Shared register arbiter: three requesters compete round-robin for one DATA_W register.
// Latency: req in cycle N -> grant in N+1; each granted cycle with req[g] high loads data_out, valid next cycle.
// Backpressure: no preemption; grant held until req[g] drops (or MAX_HOLD loads when ARB_HOLD_LIMIT_EN is defined),
//    then one RELEASE cycle and at least one IDLE cycle before the next grant.
//
// Ports:
//    clk, reset        - clock, synchronous active-high reset
//    req[2:0]          - per-requester request
//    data0/1/2         - requester write data
//    grant[2:0]        - registered one-hot grant (or zero)
//    data_out          - the shared register
//    valid             - data_out was loaded on the previous edge
//    busy              - FSM is not IDLE
// Optional feature macro: ARB_HOLD_LIMIT_EN (cap a grant at MAX_HOLD loads).
module shared_reg_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        req,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   output logic [2:0]        grant,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              busy
);

   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
      $error("shared_reg_arbiter: MAX_HOLD must be in 1..15");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        grant_q, grant_d;
   logic [1:0]        gidx_q,  gidx_d;   // index of the current grant holder
   logic [1:0]        last_q,  last_d;   // index of the most recently released holder
   logic [3:0]        hold_q,  hold_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              valid_q, valid_d;

   logic [1:0]        cand0, cand1, cand2, winner;
   logic [3:0]        hold_inc;
   logic              req_g;
   logic [DATA_W-1:0] data_sel;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] i);
      logic [2:0] oh;
      oh = 3'b000;
      case (i)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // Round-robin search order starts just after the last holder.
   always_comb begin
      cand0 = next_idx(last_q);
      cand1 = next_idx(cand0);
      cand2 = next_idx(cand1);
      if (req[cand0])      winner = cand0;
      else if (req[cand1]) winner = cand1;
      else                 winner = cand2;
   end

   // Request and data of the current holder.
   always_comb begin
      req_g    = 1'b0;
      data_sel = data0;
      case (gidx_q)
         2'd0: begin req_g = req[0]; data_sel = data0; end
         2'd1: begin req_g = req[1]; data_sel = data1; end
         2'd2: begin req_g = req[2]; data_sel = data2; end
         default: begin req_g = 1'b0; data_sel = data0; end
      endcase
   end

   assign hold_inc = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      hold_d  = hold_q;
      data_d  = data_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = 3'b000;
            if (req != 3'b000) begin
               gidx_d  = winner;
               grant_d = onehot(winner);
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (req_g) begin
               data_d  = data_sel;
               valid_d = 1'b1;
               hold_d  = hold_inc;
`ifdef ARB_HOLD_LIMIT_EN
               // The load that reaches the limit is still performed; the grant ends with it.
               if (hold_inc == 4'(MAX_HOLD)) begin
                  grant_d = 3'b000;
                  state_d = RELEASE;
               end
`endif
            end else begin
               grant_d = 3'b000;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            grant_d = 3'b000;
            last_d  = gidx_q;
            hold_d  = 4'd0;
            state_d = IDLE;
         end
         default: begin
            grant_d = 3'b000;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 3'b000;
         gidx_q  <= 2'd0;
         last_q  <= 2'd2;
         hold_q  <= 4'd0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign grant    = grant_q;
   assign data_out = data_q;
   assign valid    = valid_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic [7:0] data0, data1, data2;
   logic [2:0] grant;
   logic [7:0] data_out;
   logic       valid, busy;

   shared_reg_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset), .req(req),
      .data0(data0), .data1(data1), .data2(data2),
      .grant(grant), .data_out(data_out), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         row;
      logic [2:0] g;
      logic       v;
      logic [7:0] d;
      logic       b;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   row_n  = 0;
   int   popped = 0;
   bit   done   = 0;

   // Apply one input vector for the next edge and queue the outputs expected after it.
   task automatic vec(input logic r, input logic [2:0] rq,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [2:0] eg, input logic ev, input logic [7:0] ed, input logic eb);
      exp_t e;
      @(negedge clk);
      reset = r; req = rq; data0 = d0; data1 = d1; data2 = d2;
      e.row = row_n; e.g = eg; e.v = ev; e.d = ed; e.b = eb;
      exp_q.push_back(e);
      row_n++;
   endtask

   // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            checks++;
            if (grant !== e.g) begin
               errors++;
               $display("FAIL row%0d grant: got %b expected %b", e.row, grant, e.g);
            end
            checks++;
            if (valid !== e.v) begin
               errors++;
               $display("FAIL row%0d valid: got %b expected %b", e.row, valid, e.v);
            end
            checks++;
            if (data_out !== e.d) begin
               errors++;
               $display("FAIL row%0d data_out: got %h expected %h", e.row, data_out, e.d);
            end
            checks++;
            if (busy !== e.b) begin
               errors++;
               $display("FAIL row%0d busy: got %b expected %b", e.row, busy, e.b);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req = 3'b000; data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;

      // Reset state, then a single requester for three transfer cycles.
      vec(1, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 0);
      vec(1, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 0);
      vec(0, 3'b001, 8'hA5, 8'h00, 8'h00, 3'b001, 0, 8'h00, 1);
      vec(0, 3'b001, 8'hA5, 8'h00, 8'h00, 3'b001, 1, 8'hA5, 1);
      vec(0, 3'b001, 8'hA5, 8'h00, 8'h00, 3'b001, 1, 8'hA5, 1);
      vec(0, 3'b001, 8'hA5, 8'h00, 8'h00, 3'b001, 1, 8'hA5, 1);
      vec(0, 3'b000, 8'hA5, 8'h00, 8'h00, 3'b000, 0, 8'hA5, 1);
      vec(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'hA5, 0);
      vec(0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'hA5, 0);

      // last=0, req=110: requester 1 first, then requester 2; requester 0 ignored while 2 holds.
      vec(0, 3'b110, 8'h00, 8'h3C, 8'hC3, 3'b010, 0, 8'hA5, 1);
      vec(0, 3'b110, 8'h00, 8'h3C, 8'hC3, 3'b010, 1, 8'h3C, 1);
      vec(0, 3'b110, 8'h00, 8'h77, 8'hC3, 3'b010, 1, 8'h77, 1);
      vec(0, 3'b100, 8'h00, 8'h99, 8'hC3, 3'b000, 0, 8'h77, 1);
      vec(0, 3'b100, 8'h00, 8'h99, 8'hC3, 3'b000, 0, 8'h77, 0);
      vec(0, 3'b100, 8'h00, 8'h99, 8'hC3, 3'b100, 0, 8'h77, 1);
      vec(0, 3'b101, 8'h11, 8'h99, 8'hC3, 3'b100, 1, 8'hC3, 1);
      vec(0, 3'b001, 8'h11, 8'h99, 8'h5E, 3'b000, 0, 8'hC3, 1);
      vec(0, 3'b001, 8'h11, 8'h99, 8'h5E, 3'b000, 0, 8'hC3, 0);
      vec(0, 3'b001, 8'h11, 8'h99, 8'h5E, 3'b001, 0, 8'hC3, 1);
      vec(0, 3'b000, 8'h11, 8'h99, 8'h5E, 3'b000, 0, 8'hC3, 1);
      vec(0, 3'b000, 8'h11, 8'h99, 8'h5E, 3'b000, 0, 8'hC3, 0);

      // Reset during requester 1's second grant cycle aborts the transfer.
      vec(0, 3'b010, 8'h00, 8'h5A, 8'h00, 3'b010, 0, 8'hC3, 1);
      vec(0, 3'b010, 8'h00, 8'h5A, 8'h00, 3'b010, 1, 8'h5A, 1);
      vec(1, 3'b010, 8'h00, 8'h66, 8'h00, 3'b000, 0, 8'h00, 0);
      vec(0, 3'b011, 8'h00, 8'h66, 8'h00, 3'b001, 0, 8'h00, 1);
      vec(0, 3'b000, 8'h00, 8'h66, 8'h00, 3'b000, 0, 8'h00, 1);
      vec(0, 3'b000, 8'h00, 8'h66, 8'h00, 3'b000, 0, 8'h00, 0);

      // All three requesting continuously from reset.
      vec(1, 3'b111, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 0);
      vec(0, 3'b111, 8'h00, 8'h00, 8'h00, 3'b001, 0, 8'h00, 1);
`ifdef ARB_HOLD_LIMIT_EN
      for (int k = 0; k < 4; k++)
         vec(0, 3'b111, 8'h10 + 8'(k), 8'hEE, 8'hEE, (k == 3) ? 3'b000 : 3'b001, 1, 8'h10 + 8'(k), 1);
      vec(0, 3'b111, 8'hEE, 8'hEE, 8'hEE, 3'b000, 0, 8'h13, 0);
      vec(0, 3'b111, 8'hEE, 8'hEE, 8'hEE, 3'b010, 0, 8'h13, 1);
      for (int k = 0; k < 4; k++)
         vec(0, 3'b111, 8'hEE, 8'h20 + 8'(k), 8'hEE, (k == 3) ? 3'b000 : 3'b010, 1, 8'h20 + 8'(k), 1);
      vec(0, 3'b111, 8'hEE, 8'hEE, 8'hEE, 3'b000, 0, 8'h23, 0);
      vec(0, 3'b111, 8'hEE, 8'hEE, 8'hEE, 3'b100, 0, 8'h23, 1);
      for (int k = 0; k < 4; k++)
         vec(0, 3'b111, 8'hEE, 8'hEE, 8'h30 + 8'(k), (k == 3) ? 3'b000 : 3'b100, 1, 8'h30 + 8'(k), 1);
      vec(0, 3'b111, 8'hEE, 8'hEE, 8'hEE, 3'b000, 0, 8'h33, 0);
      vec(0, 3'b111, 8'hEE, 8'hEE, 8'hEE, 3'b001, 0, 8'h33, 1);
`else
      // Without the hold limit requester 0 keeps the grant well past hold_cnt saturation.
      for (int k = 0; k < 20; k++)
         vec(0, 3'b111, 8'h40 + 8'(k), 8'hEE, 8'hEE, 3'b001, 1, 8'h40 + 8'(k), 1);
`endif

      @(posedge clk);
      #3;
      done = 1;
      checks++;
      if (exp_q.size() != 0 || popped != row_n) begin
         errors++;
         $display("FAIL drain: got %0d rows checked expected %0d", popped, row_n);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each requester data bus and of data_out.
REQ-002 SHALL have parameter MAX_HOLD, default 4, legal range 1..15: maximum consecutive transfer cycles per grant when ARB_HOLD_LIMIT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 3 bits: per-requester access request, bit i for requester i.
REQ-006 SHALL have ports data0, data1, data2, input, DATA_W bits each: write data of requesters 0..2.
REQ-007 SHALL have port grant, output, 3 bits: registered one-hot grant, or all-zero.
REQ-008 SHALL have port data_out, output, DATA_W bits: the shared register.
REQ-009 SHALL have port valid, output, 1 bit: data_out was loaded on the previous clock edge.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-012 IDLE, any req bit high: SHALL select a winner by round-robin, searching from last+1 mod 3 upward with wrap-around; on the next edge it SHALL set grant to the winner's one-hot and enter GRANT, so req high in cycle N gives grant in cycle N+1.
REQ-013 IDLE, req==0: SHALL stay in IDLE with grant=0.
REQ-014 GRANT, req[g]==1 (g = granted index): SHALL load data_out from data<g>, set valid=1 on that edge, and increment hold_cnt (4-bit, saturating at 15).
REQ-015 GRANT, req[g]==0: SHALL perform no load, set valid=0, and enter RELEASE.
REQ-016 Requests from non-granted requesters SHALL be ignored while in GRANT; there is no preemption.
REQ-017 RELEASE: SHALL last exactly one cycle with grant=0 and valid=0, set last=g, clear hold_cnt, and enter IDLE. This guarantees at least two dead cycles between successive grants (RELEASE plus IDLE).
REQ-018 data_out SHALL hold its value in every cycle without a load.
REQ-019 Simultaneous requests SHALL resolve purely by the round-robin pointer; every continuously requesting requester SHALL be granted within 3 grant periods.

Reset
REQ-020 reset high at a clock edge SHALL force: state=IDLE, grant=0, data_out=0, valid=0, busy=0, hold_cnt=0, last=2 (requester 0 has first priority).
REQ-021 reset SHALL dominate all other inputs at the same edge, including mid-GRANT, and SHALL abort the transfer with no further load.

Configuration
REQ-022 Macro ARB_HOLD_LIMIT_EN, when defined: a load edge that brings hold_cnt to MAX_HOLD SHALL also move the FSM to RELEASE, even with req[g] still high.
REQ-023 ARB_HOLD_LIMIT_EN, when undefined: grant SHALL persist until req[g] drops, and hold_cnt saturation SHALL have no functional effect.

Verification
REQ-024 Scenario: after reset, req=3'b001, data0=8'hA5 held 3 cycles, then req=0 -> grant=001 from the 2nd cycle; data_out=A5 with valid=1 for 3 cycles; then RELEASE and IDLE; busy falls 2 cycles after req drops.
REQ-025 Scenario: req=3'b111 held continuously, ARB_HOLD_LIMIT_EN defined, MAX_HOLD=4 -> grants in order 001, 010, 100, 001; each grant lasts 4 cycles with valid=1, separated by one RELEASE cycle and one IDLE cycle.
REQ-026 Scenario: same stimulus, macro undefined -> grant stays 001 indefinitely; 010 is never granted.
REQ-027 Scenario: reset asserted in the 2nd GRANT cycle of requester 1 -> next cycle grant=0, valid=0, data_out=8'h00, busy=0; requester 0 wins the first grant after reset.
REQ-028 Scenario: req=3'b110 at last=0 -> requester 1 granted first; after it releases, requester 2 is granted next.
